// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, controller states and flag positions.
package alu_ctrl_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_ORR  = 3'b011;
    localparam logic [2:0] OP_FADD = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_WAIT = 2'b10,
        ST_RESP = 2'b11
    } state_t;

    // Bit positions inside the {N,Z,C,V} flag nibble
    localparam int N = 3;
    localparam int Z = 2;
    localparam int C = 1;
    localparam int V = 0;

    function automatic logic is_short_op(input logic [2:0] op);
        return (op <= OP_ORR);
    endfunction

    // Unsupported opcodes report a zero result, so only Z is set
    function automatic logic [3:0] illegal_flags();
        logic [3:0] f;
        f    = 4'b0000;
        f[Z] = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-requester round-robin grant: on a tie the requester that was not served last wins.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // One-hot grant decode
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters; long-path FADD results get FP_WAIT settle cycles.
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned FP_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req0_op,
    input  logic [2:0]  req1_op,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_flags,
    output logic        busy
);

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        gnt_q, gnt_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [2:0]  alu_ctrl_q, alu_ctrl_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic [3:0]  rsp_flags_q, rsp_flags_d;
    logic [1:0]  rsp_valid_q, rsp_valid_d;

    logic [1:0]  grant_s;
    logic [1:0]  req_ready_s;
    logic        hs_req_s;
    logic        hs_rsp_s;
    logic [1:0]  gnt_mask_s;

    rr_arb2 u_arb (
        .valid      (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant_s)
    );

    // Ready is offered only in IDLE, only to the winner, and never while in reset
    always_comb begin
        if (state_q == ST_IDLE && reset) begin
            req_ready_s = grant_s;
        end else begin
            req_ready_s = 2'b00;
        end
    end

    assign hs_req_s   = |(req_valid & req_ready_s);
    assign hs_rsp_s   = rsp_valid_q[gnt_q] & rsp_ready[gnt_q];
    assign gnt_mask_s = gnt_q ? 2'b10 : 2'b01;

    // Controller next state and datapath capture
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_ctrl_d   = alu_ctrl_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_valid_d  = rsp_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (hs_req_s) begin
                    gnt_d      = grant_s[1];
                    alu_a_d    = grant_s[1] ? req1_a  : req0_a;
                    alu_b_d    = grant_s[1] ? req1_b  : req0_b;
                    alu_ctrl_d = grant_s[1] ? req1_op : req0_op;
                    state_d    = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (alu_ctrl_q == OP_FADD) begin
                    cnt_d   = 4'(FP_WAIT - 1);
                    state_d = ST_WAIT;
                end else if (is_short_op(alu_ctrl_q)) begin
                    rsp_result_d = alu_result;
                    rsp_flags_d  = alu_flags;
                    rsp_valid_d  = gnt_mask_s;
                    state_d      = ST_RESP;
                end else begin
                    rsp_result_d = 32'h0000_0000;
                    rsp_flags_d  = illegal_flags();
                    rsp_valid_d  = gnt_mask_s;
                    state_d      = ST_RESP;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    rsp_result_d = alu_result;
                    rsp_flags_d  = alu_flags;
                    rsp_valid_d  = gnt_mask_s;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (hs_rsp_s) begin
                    last_grant_d = gnt_q;
                    rsp_valid_d  = 2'b00;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                rsp_valid_d = 2'b00;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            cnt_q        <= 4'd0;
            alu_a_q      <= 32'h0000_0000;
            alu_b_q      <= 32'h0000_0000;
            alu_ctrl_q   <= 3'b000;
            rsp_result_q <= 32'h0000_0000;
            rsp_flags_q  <= 4'b0000;
            rsp_valid_q  <= 2'b00;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign req_ready  = req_ready_s;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_ctrl   = alu_ctrl_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
